// File: rtl/pito_prog_loader.sv
// pito_prog_loader: turns a framed valid/ready word stream into IMEM/DMEM writes and
//   holds the pito core in reset until a START frame arrives.
// Latency: every write strobe is registered, so it appears the cycle after its payload word is accepted.
// Backpressure: s_ready is high while loading (except the first cycle out of reset) and low in RUN.
// Optional feature macro: PITO_LOADER_CHECKSUM_EN (per-segment checksum word).
//
// Ports:
//   clk, pito_io_rst_n          clock, async active-low reset
//   s_valid/s_ready/s_data      input word stream (header, payload[, checksum])
//   reload_i                    pulse in RUN to go back to load mode
//   imem_w_en/addr/wdata        IMEM write port
//   dmem_w_en/addr/wdata        DMEM write port
//   core_rst_n                  core reset, low while loading
//   busy                        a segment is in progress
//   err                         sticky error, cleared by reload
//
// Header word: [31:30] cmd (00 IMEM, 01 DMEM, 10 START, 11 illegal),
//              [29:16] len in words, [15:0] base word address.
module pito_prog_loader #(
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 4096,
  parameter int DMEM_DEPTH = 4096,
  parameter int LEN_W      = 14,
  localparam int IMEM_AW   = $clog2(IMEM_DEPTH),
  localparam int DMEM_AW   = $clog2(DMEM_DEPTH)
) (
  input  logic               clk,
  input  logic               pito_io_rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               reload_i,
  output logic               imem_w_en,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [DATA_W-1:0]  imem_wdata,
  output logic               dmem_w_en,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               core_rst_n,
  output logic               busy,
  output logic               err
);

  localparam int BASE_W = 16;
  // One bit wider than the larger operand so base+len never overflows the compare.
  localparam int END_W  = ((LEN_W > BASE_W) ? LEN_W : BASE_W) + 1;
  localparam logic [END_W-1:0] IMEM_LIM = END_W'(IMEM_DEPTH);
  localparam logic [END_W-1:0] DMEM_LIM = END_W'(DMEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_RUN     = 2'd2
`ifdef PITO_LOADER_CHECKSUM_EN
    , S_CSUM  = 2'd3
`endif
  } state_t;

`ifdef PITO_LOADER_CHECKSUM_EN
  localparam state_t SEG_DONE = S_CSUM;
`else
  localparam state_t SEG_DONE = S_IDLE;
`endif

  state_t state_q, state_d;

  logic              rdy_en_q;    // holds s_ready low for the first cycle out of reset
  logic              tgt_dmem_q;  // current segment targets DMEM
  logic              drop_q;      // segment out of bounds: drain payload, no writes
  logic [BASE_W-1:0] cur_addr_q;
  logic [LEN_W-1:0]  cnt_q;

  // header decode straight off the stream word
  logic [1:0]        hdr_cmd;
  logic [LEN_W-1:0]  hdr_len;
  logic [BASE_W-1:0] hdr_base;
  logic [END_W-1:0]  hdr_end;
  logic              hdr_fits;

  assign hdr_cmd  = s_data[31:30];
  assign hdr_len  = s_data[16 +: LEN_W];
  assign hdr_base = s_data[15:0];
  assign hdr_end  = END_W'(hdr_base) + END_W'(hdr_len);
  assign hdr_fits = hdr_cmd[0] ? (hdr_end <= DMEM_LIM) : (hdr_end <= IMEM_LIM);

  logic seg_hdr;    // accepted IMEM/DMEM header
  logic bad_hdr;    // accepted illegal header
  logic pay_xfer;   // accepted payload word
  logic csum_bad;   // accepted checksum word that does not match

`ifdef PITO_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;
  logic        csum_xfer;
  assign csum_bad = csum_xfer && (s_data[31:0] != sum_q);
`else
  assign csum_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge pito_io_rst_n) begin
    if (!pito_io_rst_n) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    s_ready  = 1'b0;
    busy     = 1'b0;
    seg_hdr  = 1'b0;
    bad_hdr  = 1'b0;
    pay_xfer = 1'b0;
`ifdef PITO_LOADER_CHECKSUM_EN
    csum_xfer = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        s_ready = rdy_en_q;
        if (s_valid && rdy_en_q) begin
          case (hdr_cmd)
            2'b00, 2'b01: begin
              seg_hdr = 1'b1;
              state_d = (hdr_len != '0) ? S_PAYLOAD : SEG_DONE;
            end
            2'b10:   state_d = S_RUN;
            default: bad_hdr = 1'b1;
          endcase
        end
      end
      S_PAYLOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          pay_xfer = 1'b1;
          if (cnt_q == LEN_W'(1)) state_d = SEG_DONE;
        end
      end
`ifdef PITO_LOADER_CHECKSUM_EN
      S_CSUM: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          csum_xfer = 1'b1;
          state_d   = S_IDLE;
        end
      end
`endif
      S_RUN: begin
        if (reload_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge pito_io_rst_n) begin
    if (!pito_io_rst_n) begin
      rdy_en_q   <= 1'b0;
      tgt_dmem_q <= 1'b0;
      drop_q     <= 1'b0;
      cur_addr_q <= '0;
      cnt_q      <= '0;
      imem_w_en  <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_w_en  <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      core_rst_n <= 1'b0;
      err        <= 1'b0;
`ifdef PITO_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      rdy_en_q   <= 1'b1;
      imem_w_en  <= 1'b0;
      dmem_w_en  <= 1'b0;
      core_rst_n <= (state_d == S_RUN);

      if (seg_hdr) begin
        tgt_dmem_q <= hdr_cmd[0];
        cur_addr_q <= hdr_base;
        cnt_q      <= hdr_len;
        drop_q     <= !hdr_fits;
`ifdef PITO_LOADER_CHECKSUM_EN
        sum_q      <= '0;
`endif
      end

      if (pay_xfer) begin
        cnt_q      <= cnt_q - LEN_W'(1);
        cur_addr_q <= cur_addr_q + BASE_W'(1);
`ifdef PITO_LOADER_CHECKSUM_EN
        sum_q      <= sum_q + s_data[31:0];
`endif
        // bounds were checked once on the header, so the address cannot
        // pass depth-1 for any segment that is actually written
        if (!drop_q) begin
          if (tgt_dmem_q) begin
            dmem_w_en  <= 1'b1;
            dmem_addr  <= cur_addr_q[DMEM_AW-1:0];
            dmem_wdata <= s_data;
          end else begin
            imem_w_en  <= 1'b1;
            imem_addr  <= cur_addr_q[IMEM_AW-1:0];
            imem_wdata <= s_data;
          end
        end
      end

      if (state_q == S_RUN && reload_i) begin
        err <= 1'b0;
      end else if (bad_hdr || csum_bad || (seg_hdr && hdr_len != '0 && !hdr_fits)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pito_prog_loader.sv
// Bench for pito_prog_loader: frames are built at segment level, expected writes
// are queued as words are accepted, and a monitor compares each write strobe.
module tb_pito_prog_loader;

  localparam int DW    = 32;
  localparam int DEPTH = 4096;
  localparam int AW    = 12;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          s_valid  = 1'b0;
  logic [DW-1:0] s_data   = '0;
  logic          reload_i = 1'b0;
  logic          s_ready;
  logic          imem_w_en, dmem_w_en;
  logic [AW-1:0] imem_addr, dmem_addr;
  logic [DW-1:0] imem_wdata, dmem_wdata;
  logic          core_rst_n, busy, err;

  pito_prog_loader #(
    .DATA_W(DW), .IMEM_DEPTH(DEPTH), .DMEM_DEPTH(DEPTH), .LEN_W(14)
  ) dut (
    .clk(clk), .pito_io_rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .reload_i(reload_i),
    .imem_w_en(imem_w_en), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_w_en(dmem_w_en), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .core_rst_n(core_rst_n), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit exp_err = 1'b0;

  typedef struct {
    bit          dm;
    int          addr;
    logic [31:0] d;
    int          at;
  } wr_t;

  wr_t         sb_q[$];
  logic [31:0] fixed_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // write monitor / scoreboard
  always @(negedge clk) begin : mon
    wr_t         e;
    logic [44:0] act_v, want_v;
    if (rst_n && (imem_w_en || dmem_w_en)) begin
      chk("wen_exclusive", 64'(imem_w_en & dmem_w_en), 64'(0));
      act_v = dmem_w_en ? {1'b1, dmem_addr, dmem_wdata} : {1'b0, imem_addr, imem_wdata};
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got %0h want no write", act_v);
      end else begin
        e      = sb_q.pop_front();
        want_v = {e.dm, e.addr[11:0], e.d};
        chk("write_dm_addr_data", 64'(act_v), 64'(want_v));
        chk("write_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  // present one word, wait (bounded) for acceptance; 'at' is the cycle stamp
  // in which the registered write for this word must be visible
  task automatic put(input logic [31:0] w, input int gap, output int at);
    int k;
    s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = w;
    k = 0;
    @(negedge clk);
    while (!s_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("FAIL put_timeout: s_ready=%0b want 1", s_ready);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
    @(posedge clk); #1;
    at      = cyc;
    s_valid = 1'b0;
  endtask

  // reference: a segment is written in full iff base+len fits, else flagged and drained
  task automatic send_seg(input logic [1:0] cmd, input int base, input int len,
                          input int gmin, input int gmax);
    int          at;
    bit          fits;
    bit          exp_busy;
    logic [31:0] w, sum;
    wr_t         e;
    fits = (base + len) <= DEPTH;
    put({cmd, len[13:0], base[15:0]}, 0, at);
    if (len > 0 && !fits) exp_err = 1'b1;
    exp_busy = (len > 0);
`ifdef PITO_LOADER_CHECKSUM_EN
    exp_busy = 1'b1;
`endif
    chk("busy_after_hdr", 64'(busy), 64'(exp_busy));
    sum = '0;
    for (int i = 0; i < len; i++) begin
      w = (fixed_q.size() > 0) ? fixed_q.pop_front() : $urandom;
      put(w, int'($urandom_range(gmax, gmin)), at);
      sum += w;
      if (fits) begin
        e.dm = cmd[0]; e.addr = base + i; e.d = w; e.at = at;
        sb_q.push_back(e);
      end
    end
`ifdef PITO_LOADER_CHECKSUM_EN
    put(sum, 0, at);
`endif
    chk("busy_after_seg", 64'(busy), 64'(0));
    chk("err_after_seg", 64'(err), 64'(exp_err));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_imem", 64'({imem_w_en, imem_addr, imem_wdata}), 64'(0));
    chk("rst_dmem", 64'({dmem_w_en, dmem_addr, dmem_wdata}), 64'(0));
    chk("rst_ctl", 64'({s_ready, core_rst_n, busy, err}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_err = 1'b0;
    @(negedge clk);
    chk("ready_first_cycle", 64'(s_ready), 64'(0));
    @(negedge clk);
    chk("ready_after", 64'(s_ready), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic start_run();
    int at;
    chk("core_rst_before_start", 64'(core_rst_n), 64'(0));
    put(32'h8000_0000, 0, at);
    chk("core_rst_after_start", 64'(core_rst_n), 64'(1));
    chk("ready_in_run", 64'(s_ready), 64'(0));
    chk("err_in_run", 64'(err), 64'(exp_err));
    @(negedge clk);
    chk("ready_in_run_hold", 64'(s_ready), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic pulse_reload(input bit in_run);
    reload_i = 1'b1;
    @(posedge clk); #1;
    reload_i = 1'b0;
    if (in_run) exp_err = 1'b0;
    chk("core_rst_after_reload", 64'(core_rst_n), 64'(0));
    chk("ready_after_reload", 64'(s_ready), 64'(1));
    chk("err_after_reload", 64'(err), 64'(exp_err));
  endtask

  initial begin
    int at;
    int len, base;
    logic [1:0] cmd;
    wr_t e;

    #1;
    do_reset();

    // directed IMEM segment, back-to-back words
    fixed_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    send_seg(2'b00, 'h10, 4, 0, 0);

    // bubbles every other cycle on a DMEM segment
    send_seg(2'b01, 'h100, 6, 1, 1);

    // randomized legal segments with random bubbles
    for (int n = 0; n < 12; n++) begin
      cmd  = 2'($urandom_range(1, 0));
      len  = int'($urandom_range(8, 1));
      base = int'($urandom_range(DEPTH - len, 0));
      send_seg(cmd, base, len, 0, 2);
    end

    // empty segment
    send_seg(2'b00, 'h20, 0, 0, 0);

    // upper bound: last legal words, then one word over the edge
    send_seg(2'b01, DEPTH - 2, 2, 0, 0);
    send_seg(2'b01, DEPTH - 1, 2, 0, 0);

    // reload outside RUN has no effect; START with err set still releases core
    pulse_reload(1'b0);
    start_run();
    pulse_reload(1'b1);

    // illegal header
    put(32'hC000_0000, 0, at);
    exp_err = 1'b1;
    chk("err_illegal", 64'(err), 64'(exp_err));
    start_run();
    pulse_reload(1'b1);

`ifdef PITO_LOADER_CHECKSUM_EN
    // checksum good then bad
    for (int r = 0; r < 2; r++) begin
      put({2'b00, 14'd2, 16'h40 + 16'(4 * r)}, 0, at);
      put(32'd1, 0, at);
      e.dm = 1'b0; e.addr = 'h40 + 4 * r; e.d = 32'd1; e.at = at; sb_q.push_back(e);
      put(32'd2, 0, at);
      e.addr = 'h41 + 4 * r; e.d = 32'd2; e.at = at; sb_q.push_back(e);
      put((r == 0) ? 32'd3 : 32'd4, 0, at);
      if (r == 1) exp_err = 1'b1;
      chk("err_csum", 64'(err), 64'(exp_err));
    end
    start_run();
    pulse_reload(1'b1);
`endif

    // async reset after 2 of 4 payload words
    put({2'b00, 14'd4, 16'h200}, 0, at);
    for (int i = 0; i < 2; i++) begin
      put(32'h5500 + 32'(i), 0, at);
      e.dm = 1'b0; e.addr = 'h200 + i; e.d = 32'h5500 + 32'(i); e.at = at;
      sb_q.push_back(e);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    do_reset();
    // next word must be taken as a header
    send_seg(2'b01, 'h30, 1, 0, 0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
